// File: rtl/pkt_dispatch_pkg.sv
// Shared types and packet-type encodings for the packet dispatch controller.
package pkt_dispatch_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } dispatch_state_e;

  localparam int PKT_DATA = 0;
  localparam int PKT_CTRL = 1;
  localparam int PKT_RESP = 2;

endpackage

// File: rtl/pkt_dispatch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {CNT_W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_dispatch_ctrl.sv
// Latches the packet type on the eof beat and hands the packet to one of NUM_CH
// channels over valid/ready, dropping it if the channel stalls past TIMEOUT.
//
// state    | meaning
// IDLE     | accepting source beats, waiting for an eof beat
// DISPATCH | one-hot dst_valid held toward type_q until accept or timeout
module pkt_dispatch_ctrl
  import pkt_dispatch_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int TYPE_W  = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  input  logic              src_eof,
  input  logic [TYPE_W-1:0] src_type,
  output logic              src_ready,
  output logic [NUM_CH-1:0] dst_valid,
  input  logic [NUM_CH-1:0] dst_ready,
  output logic              err_type,
  output logic              drop_pulse,
  input  logic              cnt_clr,
  input  logic [TYPE_W-1:0] cnt_sel,
  output logic [CNT_W-1:0]  cnt_value
);

  localparam int TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMR_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  dispatch_state_e   state, state_d;
  logic [TMR_W-1:0]  timer, timer_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              err_d, drop_d;
  logic [NUM_CH-1:0] hs_vec;
  logic              hs;
  logic [CNT_W-1:0]  cnt_arr [NUM_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      timer      <= '0;
      type_q     <= '0;
      err_type   <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      type_q     <= type_d;
      err_type   <= err_d;
      drop_pulse <= drop_d;
    end
  end

  // src_ready is gated by rst so the framer sees backpressure throughout reset
  assign src_ready = rst && (state == IDLE);

  always_comb begin
    dst_valid = '0;
    if (state == DISPATCH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        dst_valid[i] = (type_q == TYPE_W'(i));
      end
    end
  end

  assign hs_vec = dst_valid & dst_ready;
  assign hs     = |hs_vec;

  always_comb begin
    state_d = state;
    timer_d = timer;
    type_d  = type_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (src_valid && src_eof) begin
          type_d = src_type;
          // widened compare so NUM_CH == 2**TYPE_W does not wrap to zero
          if ({1'b0, src_type} < (TYPE_W + 1)'(NUM_CH)) begin
            state_d = DISPATCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DISPATCH: begin
        if (hs) begin
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && (timer == TMR_W'(TMR_LAST))) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (hs_vec[g]),
      .value (cnt_arr[g])
    );
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_sel == TYPE_W'(i)) begin
        cnt_value = cnt_arr[i];
      end
    end
  end

endmodule

// File: tb/tb_pkt_dispatch_ctrl.sv
// Directed bench for pkt_dispatch_ctrl with a short timeout and 2-bit counters.
module tb_pkt_dispatch_ctrl;
  import pkt_dispatch_pkg::*;

  localparam int NUM_CH  = 3;
  localparam int TYPE_W  = 2;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              src_valid = 1'b0;
  logic              src_eof = 1'b0;
  logic [TYPE_W-1:0] src_type = '0;
  logic              src_ready;
  logic [NUM_CH-1:0] dst_valid;
  logic [NUM_CH-1:0] dst_ready = '0;
  logic              err_type;
  logic              drop_pulse;
  logic              cnt_clr = 1'b0;
  logic [TYPE_W-1:0] cnt_sel = '0;
  logic [CNT_W-1:0]  cnt_value;

  int checks   = 0;
  int failures = 0;

  pkt_dispatch_ctrl #(
    .NUM_CH  (NUM_CH),
    .TYPE_W  (TYPE_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_eof    (src_eof),
    .src_type   (src_type),
    .src_ready  (src_ready),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .err_type   (err_type),
    .drop_pulse (drop_pulse),
    .cnt_clr    (cnt_clr),
    .cnt_sel    (cnt_sel),
    .cnt_value  (cnt_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_cnt(input string tag, input int sel, input int exp);
    cnt_sel = TYPE_W'(sel);
    #1;
    chk(tag, 32'(cnt_value), exp);
  endtask

  task automatic clear_cnts();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic pkt_data();
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_DATA);
    dst_ready = 3'b001;
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    chk("sat_dv", 32'(dst_valid), 32'h1);
    step();
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    // reset state
    #3;
    chk("rst_src_ready", 32'(src_ready), 0);
    chk("rst_dst_valid", 32'(dst_valid), 0);
    chk("rst_err", 32'(err_type), 0);
    chk("rst_drop", 32'(drop_pulse), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_src_ready", 32'(src_ready), 1);
    rd_cnt("rst_cnt0", 0, 0);

    // type 1 with dst_ready held: single-cycle dispatch
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_CTRL);
    dst_ready = 3'b010;
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    chk("t1_dv", 32'(dst_valid), 32'h2);
    chk("t1_srdy_low", 32'(src_ready), 0);
    step();
    chk("t1_dv_off", 32'(dst_valid), 0);
    chk("t1_srdy_high", 32'(src_ready), 1);
    rd_cnt("t1_cnt1", 1, 1);
    rd_cnt("t1_sel3", 3, 0);
    dst_ready = '0;
    clear_cnts();
    rd_cnt("clr_cnt1", 1, 0);

    // non-eof beats are discarded, then eof type 0
    dst_ready = 3'b001;
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1;
      src_eof   = 1'b0;
      src_type  = TYPE_W'(PKT_RESP);
      #1;
      chk("t2_noeof_srdy", 32'(src_ready), 1);
      step();
      chk("t2_noeof_dv", 32'(dst_valid), 0);
    end
    src_eof  = 1'b1;
    src_type = TYPE_W'(PKT_DATA);
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    chk("t2_dv", 32'(dst_valid), 32'h1);
    step();
    dst_ready = '0;
    rd_cnt("t2_cnt0", 0, 1);
    rd_cnt("t2_cnt1", 1, 0);
    rd_cnt("t2_cnt2", 2, 0);

    // illegal type 3
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = 2'd3;
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    chk("t3_err", 32'(err_type), 1);
    chk("t3_dv", 32'(dst_valid), 0);
    chk("t3_srdy", 32'(src_ready), 1);
    step();
    chk("t3_err_off", 32'(err_type), 0);
    chk("t3_dv2", 32'(dst_valid), 0);
    rd_cnt("t3_cnt0", 0, 1);
    rd_cnt("t3_cnt2", 2, 0);

    // timeout: four cycles of valid then a drop
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_RESP);
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_dv_hold", 32'(dst_valid), 32'h4);
      chk("t4_no_drop", 32'(drop_pulse), 0);
      step();
    end
    chk("t4_dv_off", 32'(dst_valid), 0);
    chk("t4_drop", 32'(drop_pulse), 1);
    chk("t4_srdy", 32'(src_ready), 1);
    step();
    chk("t4_drop_off", 32'(drop_pulse), 0);
    rd_cnt("t4_cnt2", 2, 0);

    // accept in the expiry cycle wins
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_RESP);
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    step();
    step();
    step();
    chk("t4b_dv_last", 32'(dst_valid), 32'h4);
    dst_ready = 3'b100;
    step();
    dst_ready = '0;
    chk("t4b_dv_off", 32'(dst_valid), 0);
    chk("t4b_no_drop", 32'(drop_pulse), 0);
    rd_cnt("t4b_cnt2", 2, 1);

    // saturation at 3, then clear beats a same-cycle handshake
    clear_cnts();
    for (int k = 0; k < 5; k++) begin
      pkt_data();
      rd_cnt("sat_cnt0", 0, sat_exp[k]);
    end
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_DATA);
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    chk("clr_dv", 32'(dst_valid), 32'h1);
    cnt_clr = 1'b1;
    step();
    cnt_clr   = 1'b0;
    dst_ready = '0;
    rd_cnt("clr_prio_cnt0", 0, 0);

    // async reset in the middle of a dispatch
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_CTRL);
    dst_ready = 3'b010;
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    step();
    dst_ready = '0;
    rd_cnt("pre_rst_cnt1", 1, 1);
    src_valid = 1'b1;
    src_eof   = 1'b1;
    src_type  = TYPE_W'(PKT_RESP);
    step();
    src_valid = 1'b0;
    src_eof   = 1'b0;
    chk("mid_dv", 32'(dst_valid), 32'h4);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_dv", 32'(dst_valid), 0);
    chk("mid_rst_srdy", 32'(src_ready), 0);
    rd_cnt("mid_rst_cnt1", 1, 0);
    rd_cnt("mid_rst_cnt2", 2, 0);
    #1;
    rst = 1'b1;
    step();
    chk("post_rst_srdy", 32'(src_ready), 1);
    chk("post_rst_dv", 32'(dst_valid), 0);
    chk("post_rst_drop", 32'(drop_pulse), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_dispatch_ctrl.md
Name: pkt_dispatch_ctrl

Overview:
Parametrised successor of the packet-type controller. It accepts a source stream and, on the end-of-frame beat, latches the packet type. It then raises a valid/ready handshake toward one of NUM_CH destination channels and holds it until the channel accepts or a timeout expires. Per-channel saturating packet counters are readable through a select port. It sits between the ingress framer and the data/ctrl/resp consumers.

Parameters:
NUM_CH, 3, number of destination channels; type encodings 0..NUM_CH-1 (0=data, 1=ctrl, 2=resp by default)
TYPE_W, 2, width of the type field; must satisfy 2**TYPE_W >= NUM_CH
TIMEOUT, 255, cycles to wait for dst_ready before dropping the packet; 0 disables the timeout (wait forever)
CNT_W, 16, width of each per-channel packet counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
src_valid  in  1  source beat valid
src_eof  in  1  beat is the last of its packet
src_type  in  TYPE_W  packet type; sampled only on the accepted eof beat
src_ready  out  1  block can accept a source beat
dst_valid  out  NUM_CH  one-hot dispatch valid, one bit per channel
dst_ready  in  NUM_CH  per-channel accept
err_type  out  1  one-cycle pulse: accepted eof beat carried type >= NUM_CH
drop_pulse  out  1  one-cycle pulse: dispatch abandoned on timeout
cnt_clr  in  1  synchronous clear of all counters
cnt_sel  in  TYPE_W  counter read select
cnt_value  out  CNT_W  combinational read of counter[cnt_sel]; 0 if cnt_sel >= NUM_CH

Behaviour:
- Reset (rst low, async): state=IDLE, src_ready=0 while rst is low. dst_valid=0, err_type=0, drop_pulse=0, timer=0, all counters=0. This applies mid-dispatch too: dst_valid drops immediately and nothing is counted.
- States: IDLE, DISPATCH.
- IDLE: src_ready=1 and dst_valid=0.
  - Non-eof beats (src_valid & ~src_eof) are accepted and discarded.
  - On src_valid & src_eof: latch src_type into type_q.
  - If src_type < NUM_CH, go to DISPATCH next cycle.
  - Otherwise, assert err_type for exactly the next cycle and stay in IDLE.
- DISPATCH:
  - src_ready=0 and dst_valid = one-hot(type_q). Exactly one bit is set, and it stays stable until it is released.
  - dst_ready bits of other channels are ignored.
  - On dst_ready[type_q] in a cycle where dst_valid is high: the handshake completes, counter[type_q] increments, and the state goes to IDLE.
  - Timer: cleared on DISPATCH entry, increments each DISPATCH cycle without a handshake.
  - If TIMEOUT>0 and the timer reaches TIMEOUT-1 without a handshake: go to IDLE, pulse drop_pulse the next cycle, no counter increment.
  - A handshake in the same cycle as timer expiry counts as success: no drop.
- Latency:
  - eof accepted in cycle N gives dst_valid from cycle N+1.
  - If dst_ready is held high, dst_valid lasts exactly one cycle and src_ready returns in N+2.
  - Peak throughput: one packet per 2 cycles.
- Counters:
  - Increment saturates at 2**CNT_W-1.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- err_type and drop_pulse never assert in the same cycle. They are registered outputs.

Decomposition:
- pkt_dispatch_pkg holds:
  - typedef enum logic {IDLE, DISPATCH} dispatch_state_e
  - localparams PKT_DATA=0, PKT_CTRL=1, PKT_RESP=2
- Sub-module sat_counter (parameter CNT_W; ports clk, rst, clr, inc, value) is instantiated NUM_CH times in a generate loop.
- The timer and FSM stay in the top module.

Test Plan:
- Type 1, eof beat in cycle 5, dst_ready[1]=1 held -> dst_valid=3'b010 only in cycle 6; src_ready low in 6, high in 7; cnt_sel=1 reads 1.
- Three non-eof beats, then eof with type 0 -> no dst_valid during the non-eof beats; dst_valid=3'b001 the cycle after eof; counter[0]=1, others 0.
- Type 3 eof (NUM_CH=3) -> err_type high for one cycle; dst_valid stays 0; all counters unchanged; src_ready stays 1.
- TIMEOUT=4, type 2, dst_ready low -> dst_valid=3'b100 for 4 cycles, then drop_pulse for one cycle, counter[2]=0. Repeat with dst_ready[2] rising in the 4th cycle -> no drop, counter[2]=1.
- CNT_W=2, five type-0 packets -> counter[0]=3 (saturated). cnt_clr asserted in the same cycle as a 6th handshake -> counter[0]=0.
- rst asserted low mid-DISPATCH -> dst_valid=0 asynchronously, all counters 0. After release: src_ready=1 and state IDLE.
